// File: rtl/vjtag_pkg.sv
// Shared definitions for the multi-channel virtual-JTAG interface.
//   op encodings carried in ir_in[IR_W-1 -: 2], system sub-codes for OP_SYS,
//   the decoded instruction type, and the channel-index width helper.
package vjtag_pkg;

   localparam logic [1:0] OP_BYPASS = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;
   localparam logic [1:0] OP_SYS    = 2'b11;

   localparam int SYS_ID     = 0;
   localparam int SYS_STATUS = 1;

   typedef enum logic [2:0] {
      INS_BYPASS,
      INS_WRITE,
      INS_READ,
      INS_ID,
      INS_STATUS
   } instr_t;

   // A single channel still needs a one-bit index field in ir_in.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vjtag_multi_channel_interface_dr_shifter.sv
// Shared data-register shifter.
//   tck        vJTAG clock
//   aclr       synchronous active-high reset
//   cap_en     load cap_data, clear the bit counter
//   shift_en   shift tdi in at the MSB, LSB leaves first
//   tdi        serial input
//   cap_data   parallel capture value
//   sr         shift register contents (sr[0] drives tdo)
//   length_ok  exactly DATA_W bits shifted since the last capture
module vjtag_multi_channel_interface_dr_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              tck,
   input  logic              aclr,
   input  logic              cap_en,
   input  logic              shift_en,
   input  logic              tdi,
   input  logic [DATA_W-1:0] cap_data,
   output logic [DATA_W-1:0] sr,
   output logic              length_ok
);

   // Counter saturates at DATA_W+1 so any over-long shift stays distinguishable.
   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W + 1);

   logic [CNT_W-1:0] bit_cnt;

   always_ff @(posedge tck) begin
      if (aclr) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (cap_en) begin
         sr      <= cap_data;
         bit_cnt <= '0;
      end else if (shift_en) begin
         sr <= {tdi, sr[DATA_W-1:1]};
         if (bit_cnt != CNT_MAX)
            bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   assign length_ok = (bit_cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/vjtag_multi_channel_interface.sv
// Multi-channel virtual-JTAG data-register interface (tck domain only).
//   tck, aclr        clock and synchronous active-high reset
//   tdi, tdo         serial chain data (tdo is combinational)
//   v_cdr/v_sdr/v_udr virtual Capture/Shift/Update-DR strobes
//   ir_in            {op[1:0], ch[CH_W-1:0]}
//   data_sent_to_pc  read-channel sources, channel k at [k*DATA_W +: DATA_W]
//   data_from_pc     registered write-channel values, same packing
//   wr_valid         one-cycle pulse per channel after an accepted update
//   rd_ack           one-cycle pulse per channel after a read capture
//   len_err          sticky shift-length error, cleared by a STATUS capture
module vjtag_multi_channel_interface
   import vjtag_pkg::*;
#(
   parameter int                 DATA_W   = 8,
   parameter int                 NUM_CH   = 4,
   parameter logic [DATA_W-1:0]  ID_VALUE = DATA_W'(8'hA5),
   parameter logic [DATA_W-1:0]  RST_VAL  = '0,
   localparam int                CH_W     = ch_width(NUM_CH),
   localparam int                IR_W     = 2 + CH_W
) (
   input  logic                     tck,
   input  logic                     aclr,
   input  logic                     tdi,
   input  logic                     v_cdr,
   input  logic                     v_sdr,
   input  logic                     v_udr,
   input  logic [IR_W-1:0]          ir_in,
   input  logic [NUM_CH*DATA_W-1:0] data_sent_to_pc,
   output logic [NUM_CH*DATA_W-1:0] data_from_pc,
   output logic [NUM_CH-1:0]        wr_valid,
   output logic [NUM_CH-1:0]        rd_ack,
   output logic                     len_err,
   output logic                     tdo
);

   logic [1:0]        op;
   logic [CH_W-1:0]   ch;
   logic              ch_ok;
   instr_t            instr;
   logic [NUM_CH-1:0] sel_oh;
   logic [DATA_W-1:0] cap_data;
   logic [DATA_W-1:0] sr;
   logic              length_ok;
   logic              cap_en, shift_en, upd_en;
   logic              bypass_bit;
   logic [DATA_W-2:0] err_cnt;
   logic [DATA_W-1:0] ch_reg [NUM_CH];

   assign op    = ir_in[IR_W-1 -: 2];
   assign ch    = ir_in[CH_W-1:0];
   assign ch_ok = ({1'b0, ch} < (CH_W + 1)'(NUM_CH));

   always_comb begin
      instr = INS_BYPASS;
      case (op)
         OP_WRITE: if (ch_ok) instr = INS_WRITE;
         OP_READ:  if (ch_ok) instr = INS_READ;
         OP_SYS: begin
            if (ch == CH_W'(SYS_ID))          instr = INS_ID;
            else if (ch == CH_W'(SYS_STATUS)) instr = INS_STATUS;
         end
         default: instr = INS_BYPASS;
      endcase
   end

   // Strobe priority v_cdr > v_sdr > v_udr.
   assign cap_en   = v_cdr && (instr != INS_BYPASS);
   assign shift_en = v_sdr && !v_cdr && (instr != INS_BYPASS);
   assign upd_en   = v_udr && !v_cdr && !v_sdr && (instr == INS_WRITE);

   always_comb begin
      sel_oh   = '0;
      cap_data = '0;
      for (int k = 0; k < NUM_CH; k++)
         sel_oh[k] = (ch == CH_W'(k));
      case (instr)
         INS_WRITE: begin
            for (int k = 0; k < NUM_CH; k++)
               if (sel_oh[k]) cap_data = ch_reg[k];
         end
         INS_READ: begin
            for (int k = 0; k < NUM_CH; k++)
               if (sel_oh[k]) cap_data = data_sent_to_pc[k*DATA_W +: DATA_W];
         end
         INS_ID:     cap_data = ID_VALUE;
         INS_STATUS: cap_data = {err_cnt, len_err};
         default:    cap_data = '0;
      endcase
   end

   vjtag_multi_channel_interface_dr_shifter #(.DATA_W(DATA_W)) u_shifter (
      .tck       (tck),
      .aclr      (aclr),
      .cap_en    (cap_en),
      .shift_en  (shift_en),
      .tdi       (tdi),
      .cap_data  (cap_data),
      .sr        (sr),
      .length_ok (length_ok)
   );

   always_ff @(posedge tck) begin
      if (aclr) begin
         for (int k = 0; k < NUM_CH; k++)
            ch_reg[k] <= RST_VAL;
         wr_valid   <= '0;
         rd_ack     <= '0;
         len_err    <= 1'b0;
         err_cnt    <= '0;
         bypass_bit <= 1'b0;
      end else begin
         bypass_bit <= tdi;
         wr_valid   <= '0;
         rd_ack     <= '0;
         if (cap_en && instr == INS_READ)
            rd_ack <= sel_oh;
         // Reading STATUS clears it; the captured SR already holds the old value.
         if (cap_en && instr == INS_STATUS) begin
            len_err <= 1'b0;
            err_cnt <= '0;
         end
         if (upd_en) begin
            if (length_ok) begin
               for (int k = 0; k < NUM_CH; k++)
                  if (sel_oh[k]) ch_reg[k] <= sr;
               wr_valid <= sel_oh;
            end else begin
               len_err <= 1'b1;
               if (err_cnt != '1)
                  err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign data_from_pc[g*DATA_W +: DATA_W] = ch_reg[g];
   end

   assign tdo = (instr == INS_BYPASS) ? bypass_bit : sr[0];

endmodule
